ccff_loader: RTL and testbench
==============================

CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 36; number of configuration flops in the target ccff chain.
REQ-002 SHALL have parameter WORD_W, default 8; width of the bitstream input word.
REQ-003 SHALL have parameter MARKER, default 8'hA5; 8-bit integrity pattern shifted ahead of the payload.
REQ-004 prog_clk  input  1  single clock for all logic; the clock the gated chain is derived from.
REQ-005 prog_reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins a load.
REQ-007 word_in  input  WORD_W  bitstream word; bit 0 is shifted first.
REQ-008 word_valid  input  1  word_in is valid.
REQ-009 word_ready  output  1  the loader accepts word_in this cycle.
REQ-010 ccff_head  output  1  serial data into the head of the chain.
REQ-011 chain_clk_en  output  1  enable for the external clock gate on the chain's prog_clk; 1 = one shift at the next edge.
REQ-012 ccff_tail  input  1  serial data from the tail of the chain.
REQ-013 busy, done, error  output  1 each  load in progress / load complete / marker mismatch.

Function
REQ-014 SHALL implement states IDLE, MARK, LOAD and DONE.
REQ-015 IDLE->MARK on start; error and done clear on that start.
REQ-016 MARK: 8 shifts with chain_clk_en=1, ccff_head=MARKER bit i on shift i (LSB first); no words consumed; then ->LOAD.
REQ-017 LOAD: exactly CHAIN_LEN payload shifts in stream order.
REQ-018 Words per load = ceil(CHAIN_LEN/WORD_W); unused upper bits of the last word are discarded and never shifted.
REQ-019 word_ready=1 only in LOAD when the internal word buffer is empty or its last bit shifts this cycle.
REQ-020 A word transfers when word_valid&&word_ready, with zero-bubble back-to-back transfers.
REQ-021 If no payload bit is available, chain_clk_en=0 (stall); ccff_head holds its value; the shift count does not advance.
REQ-022 Shift k (0-based, counted over MARK+LOAD) with chain_clk_en=1 and k in [CHAIN_LEN, CHAIN_LEN+7]: sample ccff_tail before the edge and compare it to MARKER bit k-CHAIN_LEN.
REQ-023 Any mismatch in REQ-022 sets error (sticky until the next start).
REQ-024 After shift CHAIN_LEN+7, ->DONE; done=1 and chain_clk_en=0; DONE->IDLE on the next cycle; done stays 1 until the next start.
REQ-025 busy=1 in MARK and LOAD only.
REQ-026 start while busy is ignored; word_valid outside LOAD is ignored.
REQ-027 The shift counter is sized clog2(CHAIN_LEN+8) and does not wrap within a load.

Reset
REQ-028 Assertion of prog_reset_n=0 at any time, including mid-load, SHALL force state IDLE, counters and buffer cleared.
REQ-029 The same reset SHALL force word_ready=0, ccff_head=0, chain_clk_en=0, busy=0, done=0 and error=0, asynchronously.
REQ-030 A partially loaded chain is not repaired; software SHALL restart the load.

Structure
REQ-031 Package ccff_loader_pkg SHALL hold the state enum and the default MARKER constant.
REQ-032 Sub-module ccff_word_serializer SHALL implement the word buffer, bit index and last-word truncation; it is instanced once.
REQ-033 The FSM and the integrity check SHALL be in ccff_loader.

Verification
REQ-034 Setup for REQ-035 to REQ-038: CHAIN_LEN=36, WORD_W=8, and a behavioural 36-flop chain clocked by the gated prog_clk.
REQ-035 Start, then 5 words 0x11,0x22,0x33,0x44,0x05 with continuous valid -> 44 enabled shifts; chain holds 36 payload bits; done=1, error=0.
REQ-036 Same load with word_valid low 3 cycles between each word -> chain_clk_en=0 during the gaps; identical final chain contents and done=1.
REQ-037 Chain model with bit 20 stuck-at-0 -> error=1 at DONE.
REQ-038 prog_reset_n pulsed low after 12 shifts -> all outputs 0 immediately; a new start completes a correct load.
REQ-039 start re-pulsed during LOAD -> ignored; shift count and result unchanged.
REQ-040 CHAIN_LEN=9, WORD_W=8 -> 2 words consumed; 7 bits of word 2 discarded; 17 total shifts.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ccff_loader_pkg
// Brief    : Shared types and constants for the ccff chain loader: FSM state
//            encoding, default integrity marker and a sizing helper.
// Revision : 1.0 - initial release
// ============================================================================
package ccff_loader_pkg;

  // Loader FSM states, explicitly 2 bits wide
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MARK = 2'd1,
    ST_LOAD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Integrity pattern pushed ahead of the payload; it must reappear at the
  // chain tail exactly CHAIN_LEN shifts later.
  localparam logic [7:0] MARKER_DEFAULT = 8'hA5;
  localparam int         MARKER_BITS    = 8;

  // Number of words needed to cover a given bit count
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ccff_word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : ccff_word_serializer
// Brief    : Single-word buffer that turns bitstream words into a serial bit
//            stream, LSB first. Tracks how many words of the current load
//            have been accepted and trims the final word to the bits that
//            actually belong to the chain.
// Revision : 1.0 - initial release
// ============================================================================
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 36,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              clear,       // start of a new load
  input  logic              load_en,     // loader is in its payload phase
  input  logic              shift,       // current bit_out is consumed this cycle
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              bit_avail,
  output logic              bit_out
);

  localparam int NUM_WORDS = ceil_div(CHAIN_LEN, WORD_W);
  localparam int LAST_BITS = CHAIN_LEN - (NUM_WORDS - 1) * WORD_W;
  localparam int BC_W      = $clog2(WORD_W + 1);
  localparam int WC_W      = $clog2(NUM_WORDS + 1);

  localparam logic [BC_W-1:0] FULL_CNT  = BC_W'(WORD_W);
  localparam logic [BC_W-1:0] LAST_CNT  = BC_W'(LAST_BITS);
  localparam logic [BC_W-1:0] ONE_BIT   = BC_W'(1);
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(NUM_WORDS - 1);
  localparam logic [WC_W-1:0] ALL_WORDS = WC_W'(NUM_WORDS);
  localparam logic [WC_W-1:0] ONE_WORD  = WC_W'(1);

  logic [WORD_W-1:0] buf_q,   buf_d;
  logic [BC_W-1:0]   bits_q,  bits_d;   // valid bits still held in buf_q
  logic [WC_W-1:0]   words_q, words_d;  // words accepted during this load

  logic last_bit_going;
  logic words_left;
  logic ready_w;
  logic take;

  // Buffer, bit count and word count update; a new word may land in the
  // same cycle the previous word's last bit leaves, giving zero bubbles.
  always_comb begin
    last_bit_going = shift && (bits_q == ONE_BIT);
    words_left     = (words_q != ALL_WORDS);
    ready_w        = load_en && words_left && ((bits_q == '0) || last_bit_going);
    take           = ready_w && word_valid;

    buf_d   = buf_q;
    bits_d  = bits_q;
    words_d = words_q;

    if (shift) begin
      buf_d  = buf_q >> 1;
      bits_d = bits_q - ONE_BIT;
    end

    // The final word only contributes LAST_BITS; its upper bits stay in
    // the buffer but the count runs out before they can be shifted.
    if (take) begin
      buf_d   = word_in;
      bits_d  = (words_q == LAST_WORD) ? LAST_CNT : FULL_CNT;
      words_d = words_q + ONE_WORD;
    end

    if (clear) begin
      buf_d   = '0;
      bits_d  = '0;
      words_d = '0;
    end
  end

  // Buffer state registers
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      buf_q   <= '0;
      bits_q  <= '0;
      words_q <= '0;
    end else begin
      buf_q   <= buf_d;
      bits_q  <= bits_d;
      words_q <= words_d;
    end
  end

  assign word_ready = ready_w;
  assign bit_avail  = (bits_q != '0);
  assign bit_out    = buf_q[0];

endmodule
`default_nettype wire

// File: rtl/ccff_loader.sv
`default_nettype none
// ============================================================================
// Module   : ccff_loader
// Brief    : Loads a configuration flop chain through a gated prog_clk.
//            Shifts an 8-bit marker, then CHAIN_LEN payload bits taken from
//            a word stream, and checks that the marker emerges intact at the
//            chain tail during the final 8 shifts.
// Revision : 1.0 - initial release
// ============================================================================
module ccff_loader
  import ccff_loader_pkg::*;
#(
  parameter int         CHAIN_LEN = 36,
  parameter int         WORD_W    = 8,
  parameter logic [7:0] MARKER    = MARKER_DEFAULT
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              chain_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = $clog2(CHAIN_LEN + MARKER_BITS);

  // Shift index k runs over marker and payload shifts of one load
  localparam logic [CNT_W-1:0] MARK_LAST_K   = CNT_W'(MARKER_BITS - 1);
  localparam logic [CNT_W-1:0] CHECK_FIRST_K = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_K        = CNT_W'(CHAIN_LEN + MARKER_BITS - 1);
  localparam logic [CNT_W-1:0] ONE_K         = CNT_W'(1);

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] shift_cnt_q, shift_cnt_d;
  logic             head_q,      head_d;
  logic             error_q,     error_d;
  logic             done_q,      done_d;

  logic       ser_clear;
  logic       ser_load_en;
  logic       ser_shift;
  logic       ser_avail;
  logic       ser_bit;
  logic [2:0] check_off;
  logic       tail_bad;

  ccff_word_serializer #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W)
  ) u_serializer (
    .prog_clk     (prog_clk),
    .prog_reset_n (prog_reset_n),
    .clear        (ser_clear),
    .load_en      (ser_load_en),
    .shift        (ser_shift),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .bit_avail    (ser_avail),
    .bit_out      (ser_bit)
  );

  // Marker bit expected at the tail: shift k returns marker bit k-CHAIN_LEN
  assign check_off = 3'(shift_cnt_q - CHECK_FIRST_K);
  assign tail_bad  = chain_clk_en && (shift_cnt_q >= CHECK_FIRST_K) &&
                     (ccff_tail != MARKER[check_off]);

  // State register and loader datapath flops
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q     <= ST_IDLE;
      shift_cnt_q <= '0;
      head_q      <= 1'b0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      head_q      <= head_d;
      error_q     <= error_d;
      done_q      <= done_d;
    end
  end

  // Next-state: sequencing, shift counting and the sticky integrity flag
  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    head_d      = head_q;
    error_d     = error_q;
    done_d      = done_q;
    ser_clear   = 1'b0;

    // The count saturates at the last shift so it never wraps in a load
    if (chain_clk_en) begin
      head_d = ccff_head;
      if (shift_cnt_q != LAST_K) begin
        shift_cnt_d = shift_cnt_q + ONE_K;
      end
    end

    if (tail_bad) begin
      error_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_MARK;
          shift_cnt_d = '0;
          error_d     = 1'b0;
          done_d      = 1'b0;
          ser_clear   = 1'b1;
        end
      end
      ST_MARK: begin
        if (shift_cnt_q == MARK_LAST_K) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (chain_clk_en && (shift_cnt_q == LAST_K)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: chain enable and head data; head holds its last value on stalls
  always_comb begin
    chain_clk_en = 1'b0;
    ccff_head    = head_q;
    busy         = 1'b0;
    ser_load_en  = 1'b0;
    ser_shift    = 1'b0;

    case (state_q)
      ST_MARK: begin
        busy         = 1'b1;
        chain_clk_en = 1'b1;
        ccff_head    = MARKER[shift_cnt_q[2:0]];
      end
      ST_LOAD: begin
        busy        = 1'b1;
        ser_load_en = 1'b1;
        if (ser_avail) begin
          chain_clk_en = 1'b1;
          ccff_head    = ser_bit;
          ser_shift    = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign done  = done_q;
  assign error = error_q;

endmodule
`default_nettype wire

// File: tb/tb_ccff_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccff_loader
// Brief    : Directed bench for ccff_loader with behavioural flop chains for
//            a 36-bit and a 9-bit configuration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccff_loader;

  logic       prog_clk     = 1'b0;
  logic       prog_reset_n = 1'b0;
  logic       start_v      = 1'b0;
  logic       vld          = 1'b0;
  logic [7:0] word_in      = 8'h00;
  logic       sel          = 1'b0;   // 0: 36-bit chain DUT, 1: 9-bit chain DUT
  logic       stuck20      = 1'b0;

  logic rdy36, head36, en36, busy36, done36, err36, tail36;
  logic rdy9,  head9,  en9,  busy9,  done9,  err9,  tail9;

  logic s36, s9, v36, v9;
  assign s36 = start_v & ~sel;
  assign s9  = start_v &  sel;
  assign v36 = vld & ~sel;
  assign v9  = vld &  sel;

  logic cur_ready, cur_head, cur_en, cur_busy, cur_done, cur_err;
  assign cur_ready = sel ? rdy9  : rdy36;
  assign cur_head  = sel ? head9 : head36;
  assign cur_en    = sel ? en9   : en36;
  assign cur_busy  = sel ? busy9 : busy36;
  assign cur_done  = sel ? done9 : done36;
  assign cur_err   = sel ? err9  : err36;

  always #5 prog_clk = ~prog_clk;

  ccff_loader #(.CHAIN_LEN(36), .WORD_W(8), .MARKER(8'hA5)) u_dut36 (
    .prog_clk     (prog_clk),
    .prog_reset_n (prog_reset_n),
    .start        (s36),
    .word_in      (word_in),
    .word_valid   (v36),
    .word_ready   (rdy36),
    .ccff_head    (head36),
    .chain_clk_en (en36),
    .ccff_tail    (tail36),
    .busy         (busy36),
    .done         (done36),
    .error        (err36)
  );

  ccff_loader #(.CHAIN_LEN(9), .WORD_W(8), .MARKER(8'hA5)) u_dut9 (
    .prog_clk     (prog_clk),
    .prog_reset_n (prog_reset_n),
    .start        (s9),
    .word_in      (word_in),
    .word_valid   (v9),
    .word_ready   (rdy9),
    .ccff_head    (head9),
    .chain_clk_en (en9),
    .ccff_tail    (tail9),
    .busy         (busy9),
    .done         (done9),
    .error        (err9)
  );

  // Chains: head enters the MSB, tail is bit 0, so after a full load
  // chain[i] holds payload bit i. Flops only see enabled prog_clk edges.
  logic [35:0] chain36 = '0;
  logic [8:0]  chain9  = '0;
  logic [35:0] chain36_eff;
  assign chain36_eff = stuck20 ? (chain36 & ~(36'd1 << 20)) : chain36;
  assign tail36      = chain36_eff[0];
  assign tail9       = chain9[0];

  always @(posedge prog_clk) begin
    if (en36) chain36 <= {head36, chain36_eff[35:1]};
    if (en9)  chain9  <= {head9,  chain9[8:1]};
  end

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] stim [0:5];

  // One load: start pulse, word feeding with optional gaps (counted in
  // cycles where the loader was ready), optional stray start, optional
  // reset after a given number of shifts. Head is checked on every shift.
  task automatic run_load(input logic use9, input int n_offer, input int gap,
                          input int restart_at, input int reset_at,
                          input logic [63:0] payload,
                          output int shifts, output int stalls, output int taken);
    int   cyc       = 0;
    int   k         = 0;
    int   idx       = 0;
    int   gapcnt    = 0;
    logic fire      = 1'b0;
    logic last_head = 1'b0;
    logic finished  = 1'b0;
    logic rst_pend  = 1'b0;
    logic exp_head;
    logic [7:0] mk  = 8'hA5;
    shifts = 0;
    stalls = 0;
    taken  = 0;
    sel    = use9;
    vld    = 1'b0;
    @(negedge prog_clk);
    start_v = 1'b1;
    @(negedge prog_clk);
    start_v = 1'b0;
    chk("start_busy", cur_busy, 1);
    chk("start_clears_done_err", {cur_done, cur_err}, 0);
    while (cyc < 400) begin
      if (rst_pend) begin
        prog_reset_n = 1'b0;
        vld          = 1'b0;
        #1;
        chk("async_reset_outputs",
            {cur_ready, cur_head, cur_en, cur_busy, cur_done, cur_err}, 0);
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        finished     = 1'b1;
        break;
      end
      if (fire) begin
        idx++;
        taken++;
        gapcnt = gap;
      end
      vld     = (gapcnt == 0) && (idx < n_offer);
      word_in = (idx < 6) ? stim[idx] : 8'h00;
      if (cur_done) begin
        finished = 1'b1;
        break;
      end
      fire = vld && cur_ready;
      if (!vld && cur_ready && gapcnt > 0) gapcnt--;
      start_v = (cyc == restart_at);
      if (cur_en) begin
        if (k < 8) begin
          exp_head = mk[k[2:0]];
          chk("ready_low_in_mark", cur_ready, 0);
        end else begin
          exp_head = payload[k-8];
        end
        chk("head_bit", cur_head, exp_head);
        last_head = cur_head;
        k++;
        shifts++;
        if (k == reset_at) rst_pend = 1'b1;
      end else begin
        stalls++;
        chk("head_hold_on_stall", cur_head, last_head);
      end
      @(negedge prog_clk);
      cyc++;
    end
    vld     = 1'b0;
    start_v = 1'b0;
    chk("load_finished_in_budget", finished, 1);
  endtask

  int sh, st, tk;

  initial begin
    stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33;
    stim[3] = 8'h44; stim[4] = 8'h05; stim[5] = 8'h00;

    // Reset state
    repeat (2) @(negedge prog_clk);
    chk("reset36", {rdy36, head36, en36, busy36, done36, err36}, 0);
    chk("reset9",  {rdy9,  head9,  en9,  busy9,  done9,  err9},  0);
    prog_reset_n = 1'b1;
    @(negedge prog_clk);

    // Continuous stream: 8 marker + 36 payload shifts, one stall at LOAD entry
    run_load(1'b0, 5, 0, -1, -1, 64'h5_4433_2211, sh, st, tk);
    chk("cont_shifts", sh, 44);
    chk("cont_stalls", st, 1);
    chk("cont_words", tk, 5);
    chk("cont_done_err", {done36, err36}, 2'b10);
    chk("cont_chain", chain36, 36'h5_4433_2211);
    @(negedge prog_clk);
    chk("idle_after_done", {busy36, en36, done36, rdy36}, 4'b0010);

    // Three ready-cycles of valid low before each later word: 3 stalls each
    run_load(1'b0, 5, 3, -1, -1, 64'h5_4433_2211, sh, st, tk);
    chk("gap_shifts", sh, 44);
    chk("gap_stalls", st, 13);
    chk("gap_chain", chain36, 36'h5_4433_2211);
    chk("gap_done_err", {done36, err36}, 2'b10);

    // Flop 20 stuck at 0 corrupts the marker on its way to the tail
    stuck20 = 1'b1;
    run_load(1'b0, 5, 0, -1, -1, 64'h5_4433_2211, sh, st, tk);
    chk("stuck_done_err", {done36, err36}, 2'b11);
    stuck20 = 1'b0;

    // Reset after 12 shifts, then a clean reload
    run_load(1'b0, 5, 0, -1, 12, 64'h5_4433_2211, sh, st, tk);
    chk("reset_mid_shifts", sh, 12);
    run_load(1'b0, 5, 0, -1, -1, 64'h5_4433_2211, sh, st, tk);
    chk("reload_shifts", sh, 44);
    chk("reload_chain", chain36, 36'h5_4433_2211);
    chk("reload_done_err", {done36, err36}, 2'b10);

    // Stray start in the middle of LOAD is ignored
    run_load(1'b0, 5, 0, 15, -1, 64'h5_4433_2211, sh, st, tk);
    chk("restart_shifts", sh, 44);
    chk("restart_stalls", st, 1);
    chk("restart_chain", chain36, 36'h5_4433_2211);
    chk("restart_done_err", {done36, err36}, 2'b10);

    // 9-bit chain: two words used, only bit 0 of the second word shifted
    stim[0] = 8'hA7; stim[1] = 8'hFF; stim[2] = 8'h3C;
    run_load(1'b1, 3, 0, -1, -1, 64'h1A7, sh, st, tk);
    chk("c9_shifts", sh, 17);
    chk("c9_stalls", st, 1);
    chk("c9_words", tk, 2);
    chk("c9_chain", chain9, 9'h1A7);
    chk("c9_done_err", {done9, err9}, 2'b10);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
